// File: rtl/block_mem_ctrl.sv
// block_mem_ctrl
// Moves one 128-byte cache block (32 words) between a cache and a simple
// strobed main memory, one word at a time, with one access outstanding.
//
// Ports
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready request handshake; accepted only while idle
//   req_write           1 = writeback (cache -> memory), 0 = fill
//   req_addr            byte address; low 7 bits only pick the critical word
//   wr_valid/wr_ready   writeback word stream from the cache, in word order
//   wr_data             writeback word
//   rd_valid            one-cycle pulse per filled word (no backpressure)
//   rd_data, rd_idx     filled word and its index within the block
//   done                one-cycle pulse when the block transfer completes
//   mem_ren, mem_wen    one-cycle memory strobes (never both high)
//   mem_addr, mem_din   memory word address / write data, held after a strobe
//   mem_dout            memory read data, valid MEM_LATENCY cycles after mem_ren
//
// Build option
//   BMC_CRIT_WORD_FIRST_EN  fills start at word req_addr[6:2] and wrap around
//                           the block; writebacks always start at word 0.
module block_mem_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 32,
   parameter int MEM_LATENCY     = 4,
   parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [IDX_W-1:0]      rd_idx,
   output logic                  done,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   // Byte offset inside a block: word index plus 2 bits of byte-in-word.
   localparam int OFF_W = IDX_W + 2;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [IDX_W-1:0] LAST_XFER = IDX_W'(WORDS_PER_BLOCK - 1);
   localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(MEM_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE, WR_WAIT, WR_ISSUE, WR_LAT, RD_ISSUE, RD_LAT, DONE
   } state_t;

   state_t                       state_reg;
   logic [ADDR_WIDTH-OFF_W-1:0]  base_reg;      // block-aligned upper address bits
   logic [IDX_W-1:0]             word_idx_reg;  // word currently being moved
   logic [IDX_W-1:0]             xfer_cnt_reg;  // words moved so far (ends the block)
   logic [LAT_W-1:0]             lat_cnt_reg;

   logic [IDX_W-1:0]             start_idx;
   logic [IDX_W-1:0]             idx_inc;
   logic                         unused_bits;

   // Index arithmetic wraps naturally modulo the block size.
   assign idx_inc = word_idx_reg + IDX_W'(1);

`ifdef BMC_CRIT_WORD_FIRST_EN
   assign start_idx   = req_write ? '0 : req_addr[OFF_W-1:2];
   assign unused_bits = ^req_addr[1:0];
`else
   assign start_idx   = '0;
   assign unused_bits = ^req_addr[OFF_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         word_idx_reg <= '0;
         xfer_cnt_reg <= '0;
         lat_cnt_reg  <= '0;
         req_ready    <= 1'b1;
         wr_ready     <= 1'b0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         rd_idx       <= '0;
         done         <= 1'b0;
         mem_ren      <= 1'b0;
         mem_wen      <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
      end else begin
         // Pulsed outputs default low; each state raises them for one cycle.
         rd_valid <= 1'b0;
         done     <= 1'b0;
         mem_ren  <= 1'b0;
         mem_wen  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  base_reg     <= req_addr[ADDR_WIDTH-1:OFF_W];
                  word_idx_reg <= start_idx;
                  xfer_cnt_reg <= '0;
                  req_ready    <= 1'b0;
                  if (req_write) begin
                     wr_ready  <= 1'b1;
                     state_reg <= WR_WAIT;
                  end else begin
                     // Issue the first read straight away from the new base.
                     mem_ren   <= 1'b1;
                     mem_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], start_idx, 2'b00};
                     state_reg <= RD_ISSUE;
                  end
               end
            end

            WR_WAIT: begin
               if (wr_valid) begin
                  wr_ready  <= 1'b0;
                  mem_wen   <= 1'b1;
                  mem_din   <= wr_data;
                  mem_addr  <= {base_reg, word_idx_reg, 2'b00};
                  state_reg <= WR_ISSUE;
               end
            end

            WR_ISSUE: begin
               lat_cnt_reg <= '0;
               state_reg   <= WR_LAT;
            end

            WR_LAT: begin
               if (lat_cnt_reg == LAST_LAT) begin
                  word_idx_reg <= idx_inc;
                  xfer_cnt_reg <= xfer_cnt_reg + IDX_W'(1);
                  if (xfer_cnt_reg == LAST_XFER) begin
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     wr_ready  <= 1'b1;
                     state_reg <= WR_WAIT;
                  end
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
               end
            end

            RD_ISSUE: begin
               lat_cnt_reg <= '0;
               state_reg   <= RD_LAT;
            end

            RD_LAT: begin
               if (lat_cnt_reg == LAST_LAT) begin
                  rd_valid     <= 1'b1;
                  rd_data      <= mem_dout;
                  rd_idx       <= word_idx_reg;
                  word_idx_reg <= idx_inc;
                  xfer_cnt_reg <= xfer_cnt_reg + IDX_W'(1);
                  if (xfer_cnt_reg == LAST_XFER) begin
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     // Next read goes out while the current word is delivered.
                     mem_ren   <= 1'b1;
                     mem_addr  <= {base_reg, idx_inc, 2'b00};
                     state_reg <= RD_ISSUE;
                  end
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
               end
            end

            DONE: begin
               req_ready <= 1'b1;
               state_reg <= IDLE;
            end

            default: begin
               req_ready <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed testbench for block_mem_ctrl (DATA/ADDR width 32, 32 words,
// MEM_LATENCY 4). Expectations follow BMC_CRIT_WORD_FIRST_EN if defined.
module tb_block_mem_ctrl;

   localparam int LAT = 4;
`ifdef BMC_CRIT_WORD_FIRST_EN
   localparam int FILL_START = 13;
`else
   localparam int FILL_START = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [4:0]  rd_idx;
   logic        done;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_addr, mem_din, mem_dout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   block_mem_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_BLOCK(32), .MEM_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx), .done(done),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   // Memory model: data is a fixed function of the last read address.
   function automatic logic [31:0] model_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   logic [31:0] mem_rd_addr = 32'h0;
   always @(posedge clk) if (mem_ren) mem_rd_addr <= mem_addr;
   assign mem_dout = model_word(mem_rd_addr);

   // Cycle counter and event logger (sampled on the falling edge).
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ren_total = 0, wen_total = 0, rd_total = 0, done_total = 0, both_total = 0;
   int done_cyc = 0;
   logic [31:0] ren_addr_log [4096];
   logic [31:0] wen_addr_log [4096];
   logic [31:0] wen_din_log  [4096];
   int          wen_cyc_log  [4096];
   logic [4:0]  rd_idx_log   [4096];
   logic [31:0] rd_data_log  [4096];

   always @(negedge clk) begin
      if (mem_ren && mem_wen) both_total++;
      if (mem_ren) begin ren_addr_log[ren_total] = mem_addr; ren_total++; end
      if (mem_wen) begin
         wen_addr_log[wen_total] = mem_addr;
         wen_din_log[wen_total]  = mem_din;
         wen_cyc_log[wen_total]  = cyc;
         wen_total++;
      end
      if (rd_valid) begin
         rd_idx_log[rd_total]  = rd_idx;
         rd_data_log[rd_total] = rd_data;
         rd_total++;
      end
      if (done) begin done_cyc = cyc; done_total++; end
   end

   // ---------------- stimulus helpers (no checking of results) ----------------
   task automatic start_req(input logic wr, input logic [31:0] addr, output int t0);
      int k = 0;
      while (req_ready !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
      req_valid = 1'b1; req_write = wr; req_addr = addr;
      @(negedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
      t0 = cyc;   // first cycle after acceptance
   endtask

   task automatic wait_done(input int d0, input string name);
      int k = 0;
      while (done_total == d0 && k < 1000) begin @(negedge clk); #1; k++; end
      if (done_total == d0) begin
         checks++; failures++;
         $display("FAIL %s_timeout: done pulses=0 within 1000 cycles, required 1", name);
      end
      repeat (3) begin @(negedge clk); #1; end
   endtask

   task automatic drive_writeback(input logic [31:0] addr, input int stall_len,
                                  output int t0, output int rise_cyc);
      int sent = 0, stalled = 0, k = 0, d0;
      d0 = done_total; rise_cyc = -1;
      start_req(1'b1, addr, t0);
      while (done_total == d0 && k < 2000) begin
         if (sent == 5 && stalled < stall_len) begin
            wr_valid = 1'b0; stalled++;
         end else begin
            if (sent == 5 && stall_len > 0 && rise_cyc < 0) rise_cyc = cyc;
            wr_valid = (sent < 32);
            wr_data  = 32'hA5A5_0000 + 32'(sent);
         end
         if (wr_valid && wr_ready) sent++;
         @(negedge clk); #1; k++;
      end
      wr_valid = 1'b0;
      if (done_total == d0) begin
         checks++; failures++;
         $display("FAIL wb_timeout: done pulses=0 within 2000 cycles, required 1");
      end
      repeat (3) begin @(negedge clk); #1; end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; wr_valid = 0; wr_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_ready, wr_ready, rd_valid, done, mem_ren, mem_wen} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b, required 100000", {req_ready, wr_ready, rd_valid, done, mem_ren, mem_wen});
      end
      checks++;
      if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h, required 0", rd_data); end
      checks++;
      if (rd_idx !== 5'd0) begin failures++; $display("FAIL reset_rd_idx: got %0d, required 0", rd_idx); end
      checks++;
      if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
      checks++;
      if (mem_din !== 32'h0) begin failures++; $display("FAIL reset_mem_din: got %h, required 0", mem_din); end
      #1; rst = 1'b0;
      $display("reset: outputs sampled");
   endtask

   task automatic test_fill();
      int r0, d0, q0, w0, b0, t0, idx;
      logic [31:0] exp_addr;
      r0 = rd_total; d0 = done_total; q0 = ren_total; w0 = wen_total; b0 = both_total;
      start_req(1'b0, 32'h0000_1234, t0);
      checks++;
      if ({req_ready, mem_ren} !== 2'b01) begin
         failures++; $display("FAIL fill_busy: req_ready,mem_ren got %b, required 01", {req_ready, mem_ren});
      end
      wait_done(d0, "fill");
      exp_addr = 32'h0000_1200 + 32'(FILL_START * 4);
      checks++;
      if (ren_addr_log[q0] !== exp_addr) begin
         failures++; $display("FAIL fill_first_addr: got %h, required %h", ren_addr_log[q0], exp_addr);
      end
      checks++;
      if (rd_total - r0 != 32) begin failures++; $display("FAIL fill_rd_count: got %0d, required 32", rd_total - r0); end
      checks++;
      if (ren_total - q0 != 32) begin failures++; $display("FAIL fill_ren_count: got %0d, required 32", ren_total - q0); end
      checks++;
      if (done_total - d0 != 1) begin failures++; $display("FAIL fill_done_count: got %0d, required 1", done_total - d0); end
      checks++;
      if (done_cyc - t0 != 160) begin failures++; $display("FAIL fill_done_time: got %0d cycles, required 160", done_cyc - t0); end
      checks++;
      if (rd_idx_log[r0 + 31] !== 5'((FILL_START + 31) % 32)) begin
         failures++; $display("FAIL fill_last_idx: got %0d, required %0d", rd_idx_log[r0 + 31], (FILL_START + 31) % 32);
      end
      for (int k = 0; k < 32; k++) begin
         idx = (FILL_START + k) % 32;
         exp_addr = 32'h0000_1200 + 32'(idx * 4);
         checks++;
         if (rd_idx_log[r0 + k] !== 5'(idx) || rd_data_log[r0 + k] !== model_word(exp_addr)) begin
            failures++;
            $display("FAIL fill_word%0d: idx/data got %0d/%h, required %0d/%h",
                     k, rd_idx_log[r0 + k], rd_data_log[r0 + k], idx, model_word(exp_addr));
         end
      end
      checks++;
      if (wen_total != w0 || both_total != b0) begin
         failures++; $display("FAIL fill_no_write: wen=%0d overlap=%0d, required 0/0", wen_total - w0, both_total - b0);
      end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_back: got %b, required 1", req_ready); end
      $display("fill addr=00001234 words=%0d done_after=%0d", rd_total - r0, done_cyc - t0);
   endtask

   task automatic test_writeback();
      int w0, d0, q0, t0, rise;
      w0 = wen_total; d0 = done_total; q0 = ren_total;
      drive_writeback(32'h0000_2000, 0, t0, rise);
      checks++;
      if (wen_total - w0 != 32) begin failures++; $display("FAIL wb_wen_count: got %0d, required 32", wen_total - w0); end
      checks++;
      if (wen_addr_log[w0 + 31] !== 32'h0000_207C) begin
         failures++; $display("FAIL wb_last_addr: got %h, required 0000207c", wen_addr_log[w0 + 31]);
      end
      checks++;
      if (wen_din_log[w0 + 31] !== 32'hA5A5_001F) begin
         failures++; $display("FAIL wb_last_din: got %h, required a5a5001f", wen_din_log[w0 + 31]);
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (wen_addr_log[w0 + k] !== 32'h0000_2000 + 32'(k * 4) || wen_din_log[w0 + k] !== 32'hA5A5_0000 + 32'(k)) begin
            failures++;
            $display("FAIL wb_word%0d: addr/din got %h/%h, required %h/%h", k, wen_addr_log[w0 + k],
                     wen_din_log[w0 + k], 32'h0000_2000 + 32'(k * 4), 32'hA5A5_0000 + 32'(k));
         end
      end
      checks++;
      if (wen_cyc_log[w0 + 1] - wen_cyc_log[w0] != 2 + LAT) begin
         failures++; $display("FAIL wb_word_cost: got %0d cycles, required %0d", wen_cyc_log[w0 + 1] - wen_cyc_log[w0], 2 + LAT);
      end
      checks++;
      if (done_cyc - t0 != 192) begin failures++; $display("FAIL wb_done_time: got %0d, required 192", done_cyc - t0); end
      checks++;
      if (done_total - d0 != 1 || ren_total != q0) begin
         failures++; $display("FAIL wb_done_ren: done=%0d ren=%0d, required 1/0", done_total - d0, ren_total - q0);
      end
      $display("writeback addr=00002000 words=%0d done_after=%0d", wen_total - w0, done_cyc - t0);
   endtask

   task automatic test_wr_stall();
      int w0, d0, t0, rise;
      w0 = wen_total; d0 = done_total;
      drive_writeback(32'h0000_3000, 10, t0, rise);
      checks++;
      if (wen_total - w0 != 32) begin failures++; $display("FAIL stall_wen_count: got %0d, required 32", wen_total - w0); end
      checks++;
      if (wen_cyc_log[w0 + 5] - wen_cyc_log[w0 + 4] != 11) begin
         failures++; $display("FAIL stall_gap: got %0d cycles, required 11", wen_cyc_log[w0 + 5] - wen_cyc_log[w0 + 4]);
      end
      checks++;
      if (wen_cyc_log[w0 + 5] - rise != 1) begin
         failures++; $display("FAIL stall_resume: got %0d cycles after wr_valid, required 1", wen_cyc_log[w0 + 5] - rise);
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (wen_addr_log[w0 + k] !== 32'h0000_3000 + 32'(k * 4) || wen_din_log[w0 + k] !== 32'hA5A5_0000 + 32'(k)) begin
            failures++;
            $display("FAIL stall_word%0d: addr/din got %h/%h, required %h/%h", k, wen_addr_log[w0 + k],
                     wen_din_log[w0 + k], 32'h0000_3000 + 32'(k * 4), 32'hA5A5_0000 + 32'(k));
         end
      end
      checks++;
      if (done_total - d0 != 1) begin failures++; $display("FAIL stall_done: got %0d, required 1", done_total - d0); end
      $display("writeback_stall addr=00003000 words=%0d", wen_total - w0);
   endtask

   task automatic test_req_ignored();
      int r0, d0, q0, w0, t0, k;
      r0 = rd_total; d0 = done_total; q0 = ren_total; w0 = wen_total;
      start_req(1'b0, 32'h0000_4400, t0);
      k = 0;
      while (done_total == d0 && k < 1000) begin
         req_valid = (k % 20 == 7); req_write = 1'b1; req_addr = 32'h0000_8888;
         @(negedge clk); #1; k++;
      end
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
      wait_done(d0, "ignore");
      checks++;
      if (rd_total - r0 != 32) begin failures++; $display("FAIL ignore_rd_count: got %0d, required 32", rd_total - r0); end
      checks++;
      if (done_total - d0 != 1) begin failures++; $display("FAIL ignore_done_count: got %0d, required 1", done_total - d0); end
      checks++;
      if (wen_total != w0) begin failures++; $display("FAIL ignore_no_write: got %0d, required 0", wen_total - w0); end
      for (int j = 0; j < 32; j++) begin
         checks++;
         if (ren_addr_log[q0 + j] !== 32'h0000_4400 + 32'(j * 4)) begin
            failures++; $display("FAIL ignore_addr%0d: got %h, required %h", j, ren_addr_log[q0 + j], 32'h0000_4400 + 32'(j * 4));
         end
      end
      $display("fill_with_req_pulses addr=00004400 words=%0d", rd_total - r0);
   endtask

   task automatic test_reset_mid();
      int r0, d0, q0, t0, k;
      r0 = rd_total; d0 = done_total;
      start_req(1'b0, 32'h0000_1234, t0);
      k = 0;
      while (rd_total - r0 < 7 && k < 200) begin @(negedge clk); #1; k++; end
      @(negedge clk); #1;          // now in RD_LAT of the eighth word
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, wr_ready, rd_valid, done, mem_ren, mem_wen} !== 6'b100000) begin
         failures++;
         $display("FAIL midrst_ctrl: got %b, required 100000", {req_ready, wr_ready, rd_valid, done, mem_ren, mem_wen});
      end
      checks++;
      if (rd_data !== 32'h0 || rd_idx !== 5'd0) begin
         failures++; $display("FAIL midrst_rd: data/idx got %h/%0d, required 0/0", rd_data, rd_idx);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin
         failures++; $display("FAIL midrst_mem: addr/din got %h/%h, required 0/0", mem_addr, mem_din);
      end
      #1; rst = 1'b0;
      q0 = ren_total;
      repeat (10) begin @(negedge clk); #1; end
      checks++;
      if (done_total != d0 || ren_total != q0) begin
         failures++; $display("FAIL midrst_abort: done=%0d ren=%0d, required 0/0", done_total - d0, ren_total - q0);
      end
      r0 = rd_total; q0 = ren_total;
      start_req(1'b0, 32'h0000_1234, t0);
      wait_done(d0, "midrst_refill");
      checks++;
      if (rd_total - r0 != 32 || done_total - d0 != 1) begin
         failures++; $display("FAIL midrst_refill: rd=%0d done=%0d, required 32/1", rd_total - r0, done_total - d0);
      end
      checks++;
      if (ren_addr_log[q0] !== 32'h0000_1200 + 32'(FILL_START * 4)) begin
         failures++; $display("FAIL midrst_first_addr: got %h, required %h", ren_addr_log[q0], 32'h0000_1200 + 32'(FILL_START * 4));
      end
      checks++;
      if (rd_idx_log[r0] !== 5'(FILL_START)) begin
         failures++; $display("FAIL midrst_first_idx: got %0d, required %0d", rd_idx_log[r0], FILL_START);
      end
      $display("reset_mid_fill then refill words=%0d", rd_total - r0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_writeback();
      test_wr_stall();
      test_req_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
